// File: rtl/data_mem_initiator.sv
// data_mem_initiator
//   Processor-side initiator for a word-addressable synchronous data memory.
//   Accepts one LW/SW/LDW/SDW request at a time, sequences the memory
//   controls, captures the one-cycle-delayed read data and returns a
//   single-cycle completion pulse.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_*_i / req_ready_o    request handshake (wr, dbl, addr, wdata0/1)
//   resp_*_o                 completion pulse, error flag, loaded words
//   mem_*_o / mem_data_out_i memory control, address, write and read data
module data_mem_initiator #(
    parameter int unsigned MemDepth = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic        req_dbl_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata0_i,
    input  logic [31:0] req_wdata1_i,
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata0_o,
    output logic [31:0] resp_rdata1_o,
    output logic        mem_en_o,
    output logic        mem_mem_rd_o,
    output logic        mem_mem_wr_o,
    output logic        mem_ldw_sdw_o,
    output logic        mem_second_cycle_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_in_o,
    input  logic [31:0] mem_data_out_i
);

    typedef enum logic [2:0] {StIdle, StAcc0, StAcc1, StCap, StDone} state_e;

    // 33-bit compare so 32'hFFFFFFFF cannot wrap past the limit.
    localparam logic [32:0] Depth33 = 33'(MemDepth);

    state_e      state_q, state_d;
    logic        wr_q, wr_d;
    logic        dbl_q, dbl_d;
    logic        err_q, err_d;
    logic [31:0] wdata1_q, wdata1_d;
    // Memory address/data are separate registers so they only change when an
    // access is actually issued; errored requests leave them untouched.
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic [32:0] addr_ext;
    logic        out_of_range;

    assign addr_ext     = {1'b0, req_addr_i};
    assign out_of_range = (addr_ext >= Depth33) ||
                          (req_dbl_i && (addr_ext >= (Depth33 - 33'd1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            dbl_q       <= 1'b0;
            err_q       <= 1'b0;
            wdata1_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            dbl_q       <= dbl_d;
            err_q       <= err_d;
            wdata1_q    <= wdata1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        dbl_d       = dbl_q;
        err_d       = err_q;
        wdata1_d    = wdata1_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    wr_d     = req_wr_i;
                    dbl_d    = req_dbl_i;
                    wdata1_d = req_wdata1_i;
                    err_d    = out_of_range;
                    if (out_of_range) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StAcc0;
                        mem_addr_d  = req_addr_i;
                        mem_wdata_d = req_wdata0_i;
                    end
                end
            end
            StAcc0: begin
                if (dbl_q) begin
                    state_d     = StAcc1;
                    mem_wdata_d = wdata1_q;
                end else begin
                    state_d = wr_q ? StDone : StCap;
                end
            end
            StAcc1: begin
                // First word of a double load arrives while the second is read.
                if (!wr_q) begin
                    rdata0_d = mem_data_out_i;
                end
                state_d = wr_q ? StDone : StCap;
            end
            StCap: begin
                if (dbl_q) begin
                    rdata1_d = mem_data_out_i;
                end else begin
                    rdata0_d = mem_data_out_i;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    logic accessing;

    always_comb begin
        accessing          = (state_q == StAcc0) || (state_q == StAcc1);
        req_ready_o        = (state_q == StIdle);
        resp_valid_o       = (state_q == StDone);
        resp_err_o         = (state_q == StDone) && err_q;
        mem_en_o           = accessing;
        mem_mem_rd_o       = accessing && !wr_q;
        mem_mem_wr_o       = accessing && wr_q;
        mem_ldw_sdw_o      = accessing && dbl_q;
        mem_second_cycle_o = (state_q == StAcc1);
    end

    assign mem_address_o = mem_addr_q;
    assign mem_data_in_o = mem_wdata_q;
    assign resp_rdata0_o = rdata0_q;
    assign resp_rdata1_o = rdata1_q;

endmodule
